// File: rtl/afifo_pkg.sv
// Shared types and constants for the async-FIFO write-side traffic engine.
package afifo_pkg;

  // Default data width; matches the FIFO wdata width.
  localparam int DSIZE_DEF = 8;

  // Feedback taps for the 8-bit pattern LFSR: bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // An all-zero LFSR state never leaves zero, so a zero seed is replaced by this.
  localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } wr_state_e;

  typedef enum logic {
    PAT_INC,
    PAT_LFSR
  } pat_mode_e;

endpackage

// File: rtl/burst_pattern_gen.sv
// Data pattern source for one burst: loads a seed and mode, steps on advance.
// Holds no sequencing knowledge; the writer decides when to load and advance.
module burst_pattern_gen
  import afifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [DSIZE-1:0] seed,
  input  pat_mode_e        mode,
  output logic [DSIZE-1:0] word
);

  localparam logic [DSIZE-1:0] TAPS      = DSIZE'(LFSR_TAPS);
  localparam logic [DSIZE-1:0] ZERO_SUB  = DSIZE'(LFSR_ZERO_SEED);

  pat_mode_e        mode_q;
  logic [DSIZE-1:0] next_word;

  // Next pattern word for the latched mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    next_word = word + DSIZE'(1);
    if (mode_q == PAT_LFSR) begin
      next_word = {word[DSIZE-2:0], ^(word & TAPS)};
    end
  end

  // Word register: seed on load, next word on advance, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      word   <= '0;
      mode_q <= PAT_INC;
    end else if (load) begin
      mode_q <= mode;
      word   <= ((mode == PAT_LFSR) && (seed == '0)) ? ZERO_SUB : seed;
    end else if (advance) begin
      word   <= next_word;
    end
  end

endmodule

// File: rtl/fifo_burst_writer.sv
// Write-side producer for the asynchronous FIFO (wclk domain). Accepts a
// burst request, streams req_len+1 words into the FIFO write port while
// honouring wfull, and tags each burst with an incrementing ID.
module fifo_burst_writer
  import afifo_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEF,
  parameter int LEN_W      = 8,
  parameter int ID_W       = 32,
  parameter int GAP_CYCLES = 0
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_len,
  input  logic [DSIZE-1:0] req_seed,
  input  logic             req_mode,
  input  logic             abort,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic [ID_W-1:0]  w_burst_id,
  output logic             busy,
  output logic             done,
  output logic             done_aborted
);

  // Gap counter loads GAP_CYCLES-1 on burst end and returns to IDLE at zero.
  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  wr_state_e        state_q;
  wr_state_e        state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [ID_W-1:0]  id_q;
  logic             done_q;
  logic             done_ab_q;

  logic accept;
  logic last_word;
  logic burst_end;

  assign accept     = req_valid && req_ready;
  assign last_word  = (remaining_q == '0);
  assign burst_end  = (state_q == BURST) && (state_d != BURST);
  assign busy       = (state_q != IDLE);
  assign w_burst_id = id_q;
  assign done       = done_q;
  assign done_aborted = done_ab_q;

  // Next state, handshake and write strobe; winc tracks wfull with no register lag.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    winc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = wrst_n;
        if (req_valid && wrst_n) state_d = BURST;
      end
      BURST: begin
        winc = !wfull;
        // A write in the abort cycle still lands; the burst ends after it.
        if ((winc && last_word) || abort) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, word count, burst ID, gap timer and done reporting.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_cnt_q   <= '0;
      id_q        <= '0;
      done_q      <= 1'b0;
      done_ab_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        remaining_q <= req_len;
        id_q        <= id_q + ID_W'(1);
      end else if (winc && !last_word) begin
        remaining_q <= remaining_q - LEN_W'(1);
      end

      if (burst_end) begin
        gap_cnt_q <= GAP_LOAD;
      end else if ((state_q == GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      end

      // A last-word write wins over a coincident abort: reported as normal.
      done_q    <= burst_end;
      done_ab_q <= burst_end && !(winc && last_word);
    end
  end

  burst_pattern_gen #(
    .DSIZE(DSIZE)
  ) u_pattern (
    .clk    (wclk),
    .rst_n  (wrst_n),
    .load   (accept),
    .advance(winc),
    .seed   (req_seed),
    .mode   (pat_mode_e'(req_mode)),
    .word   (wdata)
  );

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed bench for fifo_burst_writer: a per-cycle vector table for the
// single-burst cases, plus hand-written sequences for gap timing, reset
// mid-burst and a maximum-length burst under wfull back-pressure.
module tb_fifo_burst_writer;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        req_valid, req_valid_g;
  logic        req_ready, req_ready_g;
  logic [7:0]  req_len;
  logic [7:0]  req_seed;
  logic        req_mode;
  logic        abort;
  logic        wfull;
  logic        winc, winc_g;
  logic [7:0]  wdata, wdata_g;
  logic [31:0] w_burst_id, w_burst_id_g;
  logic        busy, busy_g;
  logic        done, done_g;
  logic        done_aborted, done_aborted_g;

  always #5 wclk = ~wclk;

  fifo_burst_writer #(.DSIZE(8), .LEN_W(8), .ID_W(32), .GAP_CYCLES(0)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .req_seed(req_seed), .req_mode(req_mode), .abort(abort),
    .wfull(wfull), .winc(winc), .wdata(wdata), .w_burst_id(w_burst_id),
    .busy(busy), .done(done), .done_aborted(done_aborted)
  );

  fifo_burst_writer #(.DSIZE(8), .LEN_W(8), .ID_W(32), .GAP_CYCLES(3)) dut_gap (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid_g), .req_ready(req_ready_g),
    .req_len(req_len), .req_seed(req_seed), .req_mode(req_mode), .abort(abort),
    .wfull(wfull), .winc(winc_g), .wdata(wdata_g), .w_burst_id(w_burst_id_g),
    .busy(busy_g), .done(done_g), .done_aborted(done_aborted_g)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [7:0]  len;
    logic [7:0]  seed;
    logic        mode;
    logic        ab;
    logic        wf;
    logic        rdy;
    logic        winc;
    logic        busy;
    logic        done;
    logic        dab;
    logic [7:0]  wdata;
    logic [31:0] id;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int rv, len, seed, mode, ab, wf,
                              input int rdy, wi, bz, dn, dab, wd, id);
    vec_t v;
    v.rv = 1'(rv);     v.len = 8'(len);  v.seed = 8'(seed);
    v.mode = 1'(mode); v.ab = 1'(ab);    v.wf = 1'(wf);
    v.rdy = 1'(rdy);   v.winc = 1'(wi);  v.busy = 1'(bz);
    v.done = 1'(dn);   v.dab = 1'(dab);  v.wdata = 8'(wd);
    v.id = 32'(id);
    vecs.push_back(v);
  endfunction

  // Observed outputs packed as {ready, winc, busy, done, done_aborted, wdata, id}.
  function automatic logic [63:0] obs();
    return {19'b0, req_ready, winc, busy, done, done_aborted, wdata, w_burst_id};
  endfunction

  function automatic logic [63:0] obs_g();
    return {19'b0, req_ready_g, winc_g, busy_g, done_g, done_aborted_g, wdata_g, w_burst_id_g};
  endfunction

  function automatic logic [63:0] exp_of(input vec_t v);
    return {19'b0, v.rdy, v.winc, v.busy, v.done, v.dab, v.wdata, v.id};
  endfunction

  int  low;
  int  nwr;
  int  bad;
  logic seen;
  logic ab_at_done;

  initial begin
    wrst_n = 1'b0; req_valid = 1'b0; req_valid_g = 1'b0;
    req_len = '0; req_seed = '0; req_mode = 1'b0; abort = 1'b0; wfull = 1'b0;

    //   rv len  seed mode ab wf | rdy winc busy done dab wdata id
    // Increment burst; req_* changes during the burst must be ignored.
    add(1, 3, 'hA0, 0, 0, 0,  1, 0, 0, 0, 0, 'h00, 0);
    add(0, 0, 'hFF, 1, 0, 0,  0, 1, 1, 0, 0, 'hA0, 1);
    add(0, 0, 'hFF, 1, 0, 0,  0, 1, 1, 0, 0, 'hA1, 1);
    add(0, 0, 'hFF, 1, 0, 0,  0, 1, 1, 0, 0, 'hA2, 1);
    add(0, 0, 'hFF, 1, 0, 0,  0, 1, 1, 0, 0, 'hA3, 1);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 0, 'hA4, 1);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 0, 0, 'hA4, 1);
    // Same request, wfull for burst cycles 2-4; req_valid held during burst.
    add(1, 3, 'hA0, 0, 0, 0,  1, 0, 0, 0, 0, 'hA4, 1);
    add(1, 3, 'hA0, 0, 0, 0,  0, 1, 1, 0, 0, 'hA0, 2);
    add(1, 3, 'hA0, 0, 0, 1,  0, 0, 1, 0, 0, 'hA1, 2);
    add(1, 3, 'hA0, 0, 0, 1,  0, 0, 1, 0, 0, 'hA1, 2);
    add(0, 3, 'hA0, 0, 0, 1,  0, 0, 1, 0, 0, 'hA1, 2);
    add(0, 3, 'hA0, 0, 0, 0,  0, 1, 1, 0, 0, 'hA1, 2);
    add(0, 3, 'hA0, 0, 0, 0,  0, 1, 1, 0, 0, 'hA2, 2);
    add(0, 3, 'hA0, 0, 0, 0,  0, 1, 1, 0, 0, 'hA3, 2);
    add(0, 3, 'hA0, 0, 0, 0,  1, 0, 0, 1, 0, 'hA4, 2);
    // LFSR with zero seed -> 01, 02, 04.
    add(1, 2, 'h00, 1, 0, 0,  1, 0, 0, 0, 0, 'hA4, 2);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h01, 3);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h02, 3);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h04, 3);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 0, 'h08, 3);
    // Increment wrap FF -> 00.
    add(1, 1, 'hFF, 0, 0, 0,  1, 0, 0, 0, 0, 'h08, 3);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'hFF, 4);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h00, 4);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 0, 'h01, 4);
    // Abort on the 2nd write of a len=9 burst: 2 writes, aborted done.
    add(1, 9, 'h10, 0, 0, 0,  1, 0, 0, 0, 0, 'h01, 4);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h10, 5);
    add(0, 0, 'h00, 0, 1, 0,  0, 1, 1, 0, 0, 'h11, 5);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 1, 'h12, 5);
    // Next request gets the next ID; single-word burst.
    add(1, 0, 'h55, 0, 0, 0,  1, 0, 0, 0, 0, 'h12, 5);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h55, 6);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 0, 'h56, 6);
    // Abort coinciding with the last write reports a normal completion.
    add(1, 0, 'h20, 0, 0, 0,  1, 0, 0, 0, 0, 'h56, 6);
    add(0, 0, 'h00, 0, 1, 0,  0, 1, 1, 0, 0, 'h20, 7);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 0, 'h21, 7);
    // Abort while full: no write, aborted done, data holds.
    add(1, 4, 'h40, 0, 0, 0,  1, 0, 0, 0, 0, 'h21, 7);
    add(0, 0, 'h00, 0, 1, 1,  0, 0, 1, 0, 0, 'h40, 8);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 1, 'h40, 8);
    // Abort in IDLE is ignored.
    add(0, 0, 'h00, 0, 1, 0,  1, 0, 0, 0, 0, 'h40, 8);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 0, 0, 'h40, 8);
    // LFSR with nonzero seed: 80 -> 01 -> 02.
    add(1, 1, 'h80, 1, 0, 0,  1, 0, 0, 0, 0, 'h40, 8);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h80, 9);
    add(0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 'h01, 9);
    add(0, 0, 'h00, 0, 0, 0,  1, 0, 0, 1, 0, 'h02, 9);

    // Reset state (req_ready is held low while reset is asserted).
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    check("reset_state", obs(), 64'h0);
    check("reset_state_gap", obs_g(), 64'h0);
    wrst_n = 1'b1;
    @(posedge wclk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].rv;  req_len = vecs[i].len; req_seed = vecs[i].seed;
      req_mode  = vecs[i].mode; abort  = vecs[i].ab;  wfull    = vecs[i].wf;
      @(negedge wclk);
      check($sformatf("vec%0d", i), obs(), exp_of(vecs[i]));
      @(posedge wclk); #1;
    end
    req_valid = 1'b0; abort = 1'b0; wfull = 1'b0;

    // GAP_CYCLES=3 with req_valid held: ready low exactly 3 cycles from done.
    req_valid_g = 1'b1; req_len = 8'd1; req_seed = 8'h30; req_mode = 1'b0;
    @(negedge wclk);
    check("gap_accept_ready", 64'(req_ready_g), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge wclk); #1;
      @(negedge wclk);
      if (done_g) seen = 1'b1;
    end
    check("gap_done_seen", 64'(seen), 64'd1);
    check("gap_busy_at_done", 64'({busy_g, done_aborted_g}), 64'b10);
    low = 0;
    while (!req_ready_g && low < 10) begin
      low++;
      @(posedge wclk); #1;
      @(negedge wclk);
    end
    check("gap_ready_low_cycles", 64'(low), 64'd3);
    @(posedge wclk); #1;
    req_valid_g = 1'b0;
    @(negedge wclk);
    check("gap_second_burst", 64'({winc_g, wdata_g, w_burst_id_g}), 64'({1'b1, 8'h30, 32'd2}));

    // Reset mid-burst: winc drops at once, no done, ID restarts.
    @(posedge wclk); #1;
    req_valid = 1'b1; req_len = 8'd5; req_seed = 8'hC0; req_mode = 1'b0;
    @(posedge wclk); #1;
    req_valid = 1'b0;
    @(posedge wclk); #1;
    #2;
    check("rst_pre_write", 64'({winc, wdata}), 64'({1'b1, 8'hC1}));
    wrst_n = 1'b0;
    #1;
    check("rst_mid_burst", obs(), 64'h0);
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    check("rst_no_done", 64'({done, done_aborted, busy}), 64'h0);
    @(posedge wclk); #1;
    req_valid = 1'b1; req_len = 8'd0; req_seed = 8'h77;
    @(negedge wclk);
    check("rst_ready", 64'(req_ready), 64'd1);
    @(posedge wclk); #1;
    req_valid = 1'b0;
    @(negedge wclk);
    check("rst_next_id", 64'({winc, wdata, w_burst_id}), 64'({1'b1, 8'h77, 32'd1}));
    @(posedge wclk); #1;
    @(negedge wclk);
    check("rst_next_done", 64'({done, done_aborted}), 64'b10);

    // Maximum length (req_len=FF -> 256 words) under periodic wfull.
    @(posedge wclk); #1;
    req_valid = 1'b1; req_len = 8'hFF; req_seed = 8'h00; req_mode = 1'b0;
    @(posedge wclk); #1;
    req_valid = 1'b0;
    nwr = 0; bad = 0; seen = 1'b0; ab_at_done = 1'b1;
    for (int c = 0; c < 1000 && !seen; c++) begin
      wfull = (c % 3 == 1);
      @(negedge wclk);
      if (winc && wfull) bad++;
      if (winc) begin
        if (wdata !== 8'(nwr)) bad++;
        nwr++;
      end
      if (done) begin
        seen = 1'b1;
        ab_at_done = done_aborted;
      end
      @(posedge wclk); #1;
    end
    wfull = 1'b0;
    check("max_len_done_seen", 64'(seen), 64'd1);
    check("max_len_writes", 64'(nwr), 64'd256);
    check("max_len_data_errors", 64'(bad), 64'd0);
    check("max_len_not_aborted", 64'(ab_at_done), 64'd0);
    check("max_len_end_state", 64'({busy, wdata, w_burst_id}), 64'({1'b0, 8'h00, 32'd2}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
